pcw_boot_streamer: RTL and testbench

//  Copies the boot ROM image into PCW main RAM at address 0 after every reset, because the core overwrites that ROM area.

---
 rtl/pcw_boot_pkg.sv | 19 +
 rtl/pcw_boot_streamer.sv | 132 +++++++++++++
 tb/tb_pcw_boot_streamer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pcw_boot_pkg.sv
// Shared FSM encoding, default image geometry and machine-model codes for the PCW boot streamer.
package pcw_boot_pkg;

   typedef logic [2:0] boot_state_t;

   localparam boot_state_t ST_ARM   = 3'd0;
   localparam boot_state_t ST_FETCH = 3'd1;
   localparam boot_state_t ST_LATCH = 3'd2;
   localparam boot_state_t ST_WRITE = 3'd3;
   localparam boot_state_t ST_EXEC  = 3'd4;
   localparam boot_state_t ST_DONE  = 3'd5;

   localparam int          BOOT_LEN_PCW      = 276;
   localparam logic [15:0] EXEC_ADDR_DEFAULT = 16'h0000;

   localparam logic MODEL_8256 = 1'b0;  // 8256/8512
   localparam logic MODEL_9512 = 1'b1;  // 9512 and later

endpackage

// File: rtl/pcw_boot_streamer.sv
// Copies BOOT_LEN ROM bytes into RAM at 0 after reset/restart, one byte per 3 cycles; dn_wait holds the
// strobe, execute_enable pulses 3*BOOT_LEN+2 cycles after release. Optional checksum: BOOT_CKSUM_EN.
module pcw_boot_streamer
   import pcw_boot_pkg::*;
#(
   parameter int                BOOT_LEN  = BOOT_LEN_PCW,
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] EXEC_ADDR = ADDR_W'(EXEC_ADDR_DEFAULT)
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              restart,
   input  logic              model,
   output logic              rom_model,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              dn_go,
   output logic              dn_wr,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   input  logic              dn_wait,
   output logic [ADDR_W-1:0] execute_addr,
   output logic              execute_enable,
   output logic              busy,
   output logic              boot_err
);

`ifdef BOOT_CKSUM_EN
   localparam int CKSUM_EN = 1;
`else
   localparam int CKSUM_EN = 0;
`endif

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BOOT_LEN - 1);
   localparam logic [ADDR_W-1:0] CKSUM_IDX = ADDR_W'(BOOT_LEN);

   // The counter never wraps, so every fetched byte (checksum included) needs its own address.
   if (BOOT_LEN < 1 || (64'(BOOT_LEN) + 64'(CKSUM_EN)) > (64'd1 << ADDR_W)) begin : g_len_check
      $error("pcw_boot_streamer: BOOT_LEN does not fit in ADDR_W address bits");
   end

   boot_state_t       state;
   logic [ADDR_W-1:0] cnt;
   logic              cksum_step;
   logic              write_last;
   logic              exec_ok;

   assign cksum_step   = (CKSUM_EN != 0) && (cnt == CKSUM_IDX);
   assign write_last   = (CKSUM_EN == 0) && (cnt == LAST_IDX);
   assign rom_addr     = cnt;
   assign dn_addr      = cnt;
   assign execute_addr = EXEC_ADDR;
   assign dn_wr        = (state == ST_WRITE) && !dn_wait && !cksum_step;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state          <= ST_ARM;
         cnt            <= '0;
         rom_model      <= MODEL_8256;
         dn_data        <= '0;
         dn_go          <= 1'b0;
         busy           <= 1'b0;
         execute_enable <= 1'b0;
      end else begin
         execute_enable <= 1'b0;
         case (state)
            ST_ARM: begin
               rom_model <= (model == MODEL_9512) ? MODEL_9512 : MODEL_8256;
               cnt       <= '0;
               dn_go     <= 1'b1;
               busy      <= 1'b1;
               state     <= ST_FETCH;
            end
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               dn_data <= rom_data;
               state   <= ST_WRITE;
            end
            ST_WRITE: begin
               // The checksum byte is only summed, never written, so back-pressure does not apply.
               if (cksum_step) begin
                  state <= ST_EXEC;
               end else if (!dn_wait) begin
                  if (write_last) begin
                     state <= ST_EXEC;
                  end else begin
                     cnt   <= cnt + ADDR_W'(1);
                     state <= ST_FETCH;
                  end
               end
            end
            ST_EXEC: begin
               dn_go          <= 1'b0;
               busy           <= 1'b0;
               execute_enable <= exec_ok;
               state          <= ST_DONE;
            end
            ST_DONE: begin
               if (restart) begin
                  cnt   <= '0;
                  state <= ST_ARM;
               end
            end
            default: state <= ST_ARM;
         endcase
      end
   end

`ifdef BOOT_CKSUM_EN
   logic [7:0] cksum;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cksum    <= '0;
         boot_err <= 1'b0;
      end else if (state == ST_ARM || (state == ST_DONE && restart)) begin
         cksum    <= '0;
         boot_err <= 1'b0;
      end else if (state == ST_LATCH) begin
         cksum <= cksum + rom_data;
      end else if (state == ST_EXEC && cksum != 8'h00) begin
         boot_err <= 1'b1;
      end
   end

   assign exec_ok = (cksum == 8'h00);
`else
   assign exec_ok  = 1'b1;
   assign boot_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcw_boot_streamer.sv
// Randomised bench for pcw_boot_streamer: a byte-stream model predicts every write, its timing and the final pulse.
module tb_pcw_boot_streamer;
   import pcw_boot_pkg::*;

   localparam int N = BOOT_LEN_PCW;
`ifdef BOOT_CKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        restart = 1'b0;
   logic        model   = 1'b0;
   logic        dn_wait = 1'b0;
   logic [7:0]  rom_data;
   logic        rom_model, dn_go, dn_wr, execute_enable, busy, boot_err;
   logic [15:0] rom_addr, dn_addr, execute_addr;
   logic [7:0]  dn_data;

   logic [7:0]  rom_mem [65536];
   bit          wait_sched [4096];
   int          errors = 0;
   int          checks = 0;
   int          cur_cyc = 0;

   pcw_boot_streamer dut (
      .clk_sys(clk_sys), .reset(reset), .restart(restart), .model(model),
      .rom_model(rom_model), .rom_addr(rom_addr), .rom_data(rom_data),
      .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
      .dn_wait(dn_wait), .execute_addr(execute_addr),
      .execute_enable(execute_enable), .busy(busy), .boot_err(boot_err)
   );

   always #5 clk_sys = ~clk_sys;

   // Synchronous boot ROM: data for an address appears one cycle later.
   always @(posedge clk_sys) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cur_cyc, got, exp);
      end
   endtask

   // Image bytes 0..N-1, plus the byte that makes the 8-bit sum of 0..N zero (optionally spoiled).
   task automatic fill_rom(input bit rnd, input bit corrupt);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < N; i++) begin
         rom_mem[i] = rnd ? 8'($urandom) : 8'(i);
         s += rom_mem[i];
      end
      rom_mem[N] = (8'h00 - s) + (corrupt ? 8'h01 : 8'h00);
   endtask

   // mode 0: never wait, 1: random ~30%, 2: only the window [lo, lo+len)
   task automatic fill_wait(input int mode, input int lo, input int len);
      for (int i = 0; i < 4096; i++) begin
         wait_sched[i] = (mode == 1) ? (($urandom % 100) < 30)
                       : (mode == 2) ? (i >= lo && i < lo + len) : 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk_sys); #1;
      restart = 1'b0;
      reset   = 1'b1;
      @(posedge clk_sys); #1;
      reset   = 1'b0;
   endtask

   // Cycle 0 is the first cycle after reset release (base 0) or the cycle carrying the restart pulse (base 1).
   // Writes must come in order, at least 3 cycles apart, each in the first wait-free cycle available.
   task automatic run_copy(input int base, input bit m0, input bit toggle, input int restart_at,
                           input int abort_at);
      int         k, earliest, done;
      bit         exp_wr, exp_ok, finished;
      logic [7:0] s;
      k        = 0;
      earliest = base + 3;
      done     = -1;
      finished = 1'b0;
      s        = 8'h00;
      for (int i = 0; i <= N; i++) if (i < N || CK) s += rom_mem[i];
      exp_ok = !CK || (s == 8'h00);
      check("execute_addr", 32'(execute_addr), 32'(EXEC_ADDR_DEFAULT));
      for (int c = 0; c < 4000; c++) begin
         cur_cyc = c;
         restart = (base == 1 && c == 0) || (c == restart_at);
         model   = (toggle && c > base + 10) ? ~m0 : m0;
         dn_wait = wait_sched[c];
         if (c == abort_at) begin
            reset = 1'b1;
            @(negedge clk_sys);
            check("abort_dn_go", 32'(dn_go), 0);
            check("abort_dn_wr", 32'(dn_wr), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_dn_addr", 32'(dn_addr), 0);
            check("abort_rom_addr", 32'(rom_addr), 0);
            check("abort_dn_data", 32'(dn_data), 0);
            check("abort_rom_model", 32'(rom_model), 0);
            check("abort_exec_en", 32'(execute_enable), 0);
            return;
         end
         @(negedge clk_sys);
         exp_wr = (k < N) && (c >= earliest) && !dn_wait;
         check("dn_wr", 32'(dn_wr), 32'(exp_wr));
         if (k < N && c >= earliest) begin
            check("dn_addr", 32'(dn_addr), 32'(k));
            check("dn_data", 32'(dn_data), 32'(rom_mem[k]));
         end
         if (exp_wr) begin
            k++;
            earliest = c + 3;
            if (k == N) done = c + (CK ? 5 : 2);
         end
         check("execute_enable", 32'(execute_enable), 32'((c == done) && exp_ok));
         check("dn_go", 32'(dn_go), 32'(c > base && (done < 0 || c < done)));
         check("busy", 32'(busy), 32'(c > base && (done < 0 || c < done)));
         if (c > base) begin
            check("rom_model", 32'(rom_model), 32'(m0));
            check("boot_err", 32'(boot_err), 32'(done >= 0 && c >= done && !exp_ok));
         end
         if (done >= 0 && c == done + 2) begin
            finished = 1'b1;
            break;
         end
         @(posedge clk_sys); #1;
      end
      check("copy_complete", 32'(finished), 1);
   endtask

   initial begin
      fill_rom(1'b0, 1'b0);
      fill_wait(0, 0, 0);
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_dn_go", 32'(dn_go), 0);
      check("rst_dn_wr", 32'(dn_wr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_exec_en", 32'(execute_enable), 0);
      check("rst_rom_model", 32'(rom_model), 0);
      check("rst_dn_addr", 32'(dn_addr), 0);
      check("rst_dn_data", 32'(dn_data), 0);
      check("rst_boot_err", 32'(boot_err), 0);
      check("rst_exec_addr", 32'(execute_addr), 32'(EXEC_ADDR_DEFAULT));

      // Ramp image, no back-pressure: last write at cycle 828, execute_enable at 830.
      @(posedge clk_sys); #1;
      reset = 1'b0;
      run_copy(0, 1'b0, 1'b0, -1, -1);

      // Five wait cycles exactly on byte 10 (its WRITE starts at cycle 33).
      fill_rom(1'b1, 1'b0);
      fill_wait(2, 33, 5);
      pulse_reset();
      run_copy(0, 1'b0, 1'b0, -1, -1);

      // Random back-pressure, model=1 latched then toggled away mid-copy.
      fill_rom(1'b1, 1'b0);
      fill_wait(1, 0, 0);
      pulse_reset();
      run_copy(0, 1'b1, 1'b1, -1, -1);

      // Restart in DONE re-latches model 0; a second restart mid-copy is dropped.
      fill_wait(1, 0, 0);
      @(posedge clk_sys); #1;
      run_copy(1, 1'b0, 1'b0, 200 + int'($urandom_range(0, 300)), -1);

      // Reset at byte 100's WRITE aborts; the next copy starts again from byte 0.
      fill_rom(1'b1, 1'b0);
      fill_wait(0, 0, 0);
      pulse_reset();
      run_copy(0, 1'b0, 1'b0, -1, 303);
      fill_wait(1, 0, 0);
      pulse_reset();
      run_copy(0, 1'b1, 1'b0, -1, -1);

      // Spoiled checksum byte (only matters in the checksum build), then a clean restart.
      fill_rom(1'b1, 1'b1);
      fill_wait(0, 0, 0);
      pulse_reset();
      run_copy(0, 1'b0, 1'b0, -1, -1);
      fill_rom(1'b1, 1'b0);
      @(posedge clk_sys); #1;
      run_copy(1, 1'b1, 1'b0, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
